// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue.
//   FQ_WIDTH / FQ_INDEX : MSB indices of the 32-bit data fields and the gshare index
//   FQ_DEPTH / FQ_PTR   : queue depth (power of 2, >= 2) and pointer MSB index
//   fetchPacket_t       : one buffered fetch packet
package fetch_pkg;

  localparam int FQ_WIDTH = 31;
  localparam int FQ_INDEX = 7;
  localparam int FQ_DEPTH = 4;
  localparam int FQ_PTR   = 1;

  typedef struct packed {
    logic [FQ_WIDTH:0] instr;
    logic [FQ_WIDTH:0] pc;
    logic [FQ_WIDTH:0] predictedPC;
    logic [FQ_INDEX:0] ghrIndex;
    logic [1:0]        phtState;
    logic              redirect;
  } fetchPacket_t;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Pointer / occupancy control for the fetch queue.
// Inputs : clk, globalResetN (async, active-low), fetchValid, decReady,
//          mispredictFlush, earlyMisdirect
// Outputs: wr_en (entry[wr_ptr] is written at the next edge), wr_ptr, rd_ptr,
//          full, empty -- all derived from registered state except wr_en.
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR   = FQ_PTR
) (
  input  logic         clk,
  input  logic         globalResetN,
  input  logic         fetchValid,
  input  logic         decReady,
  input  logic         mispredictFlush,
  input  logic         earlyMisdirect,
  output logic         wr_en,
  output logic [PTR:0] wr_ptr,
  output logic [PTR:0] rd_ptr,
  output logic         full,
  output logic         empty
);

  localparam logic [PTR+1:0] FULL_COUNT = (PTR+2)'(DEPTH);

  logic [PTR:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR+1:0] count_q,  count_d;
  logic           flush, enq, deq;

  always_comb begin
    full     = (count_q == FULL_COUNT);
    empty    = (count_q == '0);
    flush    = mispredictFlush | earlyMisdirect;
    // Flush dominates: neither the incoming packet nor the head moves.
    enq      = fetchValid & ~full & ~flush;
    deq      = ~empty & decReady & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide, so they wrap for free.
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_en  = enq;
  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: decoupling FIFO between instruction fetch and decode/rename.
// Inputs : clk, globalResetN (async, active-low), fetchValid + packet fields
//          (instr, instrPC, predictedPCF, GHRIndex, PHTState, redirect),
//          mispredictFlush / earlyMisdirect (discard everything), decReady.
// Outputs: freeze (= full, stalls the fetch register), decValid and the head
//          packet fields dec*, which read as zero whenever the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH,
  parameter int INDEX = FQ_INDEX,
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR   = FQ_PTR
) (
  input  logic             clk,
  input  logic             globalResetN,
  input  logic             fetchValid,
  input  logic [WIDTH:0]   instr,
  input  logic [WIDTH:0]   instrPC,
  input  logic [WIDTH:0]   predictedPCF,
  input  logic [INDEX:0]   GHRIndex,
  input  logic [1:0]       PHTState,
  input  logic             redirect,
  input  logic             mispredictFlush,
  input  logic             earlyMisdirect,
  input  logic             decReady,
  output logic             freeze,
  output logic             decValid,
  output logic [WIDTH:0]   decInstr,
  output logic [WIDTH:0]   decPC,
  output logic [WIDTH:0]   decPredictedPC,
  output logic [INDEX:0]   decGHRIndex,
  output logic [1:0]       decPHTState,
  output logic             decRedirect
);

  logic         wr_en;
  logic [PTR:0] wr_ptr, rd_ptr;
  logic         full, empty;
  fetchPacket_t pkt_in, head;

  // Storage is intentionally not reset; validity is tracked by the count.
  fetchPacket_t mem_q [DEPTH];

  fetch_queue_ctrl #(
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_ctrl (
    .clk             (clk),
    .globalResetN    (globalResetN),
    .fetchValid      (fetchValid),
    .decReady        (decReady),
    .mispredictFlush (mispredictFlush),
    .earlyMisdirect  (earlyMisdirect),
    .wr_en           (wr_en),
    .wr_ptr          (wr_ptr),
    .rd_ptr          (rd_ptr),
    .full            (full),
    .empty           (empty)
  );

  always_comb begin
    pkt_in.instr       = instr;
    pkt_in.pc          = instrPC;
    pkt_in.predictedPC = predictedPCF;
    pkt_in.ghrIndex    = GHRIndex;
    pkt_in.phtState    = PHTState;
    pkt_in.redirect    = redirect;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= pkt_in;
  end

  // Head is read straight from the register file so a packet written at an
  // edge is presented right after it; empty forces the outputs to zero.
  always_comb begin
    head = empty ? '0 : mem_q[rd_ptr];
  end

  assign freeze         = full;
  assign decValid       = ~empty;
  assign decInstr       = head.instr;
  assign decPC          = head.pc;
  assign decPredictedPC = head.predictedPC;
  assign decGHRIndex    = head.ghrIndex;
  assign decPHTState    = head.phtState;
  assign decRedirect    = head.redirect;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetchValid = 1'b0;
  logic [31:0] instr = '0, instrPC = '0, predictedPCF = '0;
  logic [7:0]  GHRIndex = '0;
  logic [1:0]  PHTState = '0;
  logic        redirect = 1'b0;
  logic        mispredictFlush = 1'b0, earlyMisdirect = 1'b0, decReady = 1'b0;
  logic        freeze, decValid, decRedirect;
  logic [31:0] decInstr, decPC, decPredictedPC;
  logic [7:0]  decGHRIndex;
  logic [1:0]  decPHTState;

  int checks = 0;
  int errors = 0;

  fetchPacket_t model_q [$];
  logic [31:0]  delivered [$];

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .globalResetN(rst_n), .fetchValid(fetchValid),
    .instr(instr), .instrPC(instrPC), .predictedPCF(predictedPCF),
    .GHRIndex(GHRIndex), .PHTState(PHTState), .redirect(redirect),
    .mispredictFlush(mispredictFlush), .earlyMisdirect(earlyMisdirect),
    .decReady(decReady), .freeze(freeze), .decValid(decValid),
    .decInstr(decInstr), .decPC(decPC), .decPredictedPC(decPredictedPC),
    .decGHRIndex(decGHRIndex), .decPHTState(decPHTState), .decRedirect(decRedirect)
  );

  // Reference model: a plain bounded queue of packets.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else if (mispredictFlush || earlyMisdirect) begin
      model_q.delete();
    end else begin
      automatic bit do_enq = fetchValid && (model_q.size() < FQ_DEPTH);
      automatic fetchPacket_t p;
      p.instr = instr; p.pc = instrPC; p.predictedPC = predictedPCF;
      p.ghrIndex = GHRIndex; p.phtState = PHTState; p.redirect = redirect;
      if (model_q.size() > 0 && decReady) begin
        delivered.push_back(model_q[0].pc);
        void'(model_q.pop_front());
      end
      if (do_enq) model_q.push_back(p);
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic fetchPacket_t exp_p = (model_q.size() > 0) ? model_q[0] : '0;
      automatic logic exp_v = (model_q.size() > 0);
      automatic logic exp_f = (model_q.size() == FQ_DEPTH);
      automatic fetchPacket_t act_p;
      act_p.instr = decInstr; act_p.pc = decPC; act_p.predictedPC = decPredictedPC;
      act_p.ghrIndex = decGHRIndex; act_p.phtState = decPHTState; act_p.redirect = decRedirect;
      checks++;
      if (decValid !== exp_v || freeze !== exp_f || act_p !== exp_p) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual v=%b f=%b pkt=%h required v=%b f=%b pkt=%h",
                 $time, decValid, freeze, act_p, exp_v, exp_f, exp_p);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic [31:0] pc);
    instrPC = pc; instr = pc ^ 32'h0000_0013; predictedPCF = pc + 32'd8;
    GHRIndex = pc[9:2]; PHTState = pc[3:2]; redirect = pc[2];
  endtask

  // Present a packet and hold it while the queue is frozen.
  task automatic push_held(input logic [31:0] pc);
    logic fz;
    int n;
    set_pkt(pc);
    fetchValid = 1'b1;
    n = 0;
    do begin
      fz = freeze;
      step();
      n++;
    end while (fz && n < 50);
    if (fz) chk("push_timeout", 32'(fz), 32'd0);
    fetchValid = 1'b0;
  endtask

  task automatic drain();
    fetchValid = 1'b0;
    decReady = 1'b1;
    for (int i = 0; i < 20 && decValid; i++) step();
    chk("drain_empty", 32'(decValid), 32'd0);
  endtask

  task automatic chk_delivered(input string name, input logic [31:0] base, input int n);
    chk({name, "_len"}, 32'(delivered.size()), 32'(n));
    for (int i = 0; i < n && i < delivered.size(); i++)
      chk({name, "_pc"}, delivered[i], base + 32'(4 * i));
  endtask

  initial begin
    // 1. Reset
    #13;
    chk("rst_valid", 32'(decValid), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_instr", decInstr, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(decValid), 32'd0);
    // mid-operation asynchronous reset
    push_held(32'h40); push_held(32'h44);
    chk("pre_arst_valid", 32'(decValid), 32'd1);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("arst_valid", 32'(decValid), 32'd0);
    chk("arst_freeze", 32'(freeze), 32'd0);
    chk("arst_instr", decInstr, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    chk("arst_release_valid", 32'(decValid), 32'd0);

    // 2. Fill
    delivered.delete();
    decReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_freeze_pre", 32'(freeze), 32'd0);
      push_held(32'h100 + 32'(4 * i));
    end
    chk("fill_freeze", 32'(freeze), 32'd1);
    set_pkt(32'h110); fetchValid = 1'b1;
    step();
    chk("held_freeze", 32'(freeze), 32'd1);
    chk("held_head", decPC, 32'h100);

    // 3. Drain while frozen; 0x110 is still being presented
    decReady = 1'b1;
    push_held(32'h110);
    drain();
    chk_delivered("drain", 32'h100, 5);

    // 4. Simultaneous enq/deq at count 2
    delivered.delete();
    decReady = 1'b0;
    push_held(32'hA0); push_held(32'hA4);
    decReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_pkt(32'hA8 + 32'(4 * k)); fetchValid = 1'b1;
      chk("simul_head", decPC, 32'hA0 + 32'(4 * k));
      chk("simul_freeze", 32'(freeze), 32'd0);
      step();
    end
    drain();
    chk_delivered("simul", 32'hA0, 8);

    // 5. Flush with each source
    for (int s = 0; s < 2; s++) begin
      delivered.delete();
      decReady = 1'b0;
      push_held(32'h1F0); push_held(32'h1F4); push_held(32'h1F8);
      set_pkt(32'h200); fetchValid = 1'b1; decReady = 1'b1;
      if (s == 0) mispredictFlush = 1'b1; else earlyMisdirect = 1'b1;
      step();
      mispredictFlush = 1'b0; earlyMisdirect = 1'b0; fetchValid = 1'b0;
      chk("flush_valid", 32'(decValid), 32'd0);
      chk("flush_freeze", 32'(freeze), 32'd0);
      drain();
      chk("flush_delivered", 32'(delivered.size()), 32'd0);
    end

    // 6. Field integrity
    decReady = 1'b0;
    instr = 32'h0000_0067; instrPC = 32'h300; predictedPCF = 32'hDEADBEE0;
    GHRIndex = 8'hA5; PHTState = 2'b11; redirect = 1'b1; fetchValid = 1'b1;
    step();
    fetchValid = 1'b0;
    chk("fld_pred", decPredictedPC, 32'hDEADBEE0);
    chk("fld_ghr", 32'(decGHRIndex), 32'hA5);
    chk("fld_pht", 32'(decPHTState), 32'd3);
    chk("fld_redir", 32'(decRedirect), 32'd1);
    chk("fld_instr", decInstr, 32'h67);
    drain();

    // 7. Random traffic, fetch holds its packet while frozen
    for (int c = 0; c < 3000; c++) begin
      if (!(fetchValid && freeze)) begin
        fetchValid = ($urandom_range(0, 3) != 0);
        instr = $urandom(); instrPC = $urandom(); predictedPCF = $urandom();
        GHRIndex = 8'($urandom()); PHTState = 2'($urandom()); redirect = 1'($urandom());
      end
      decReady = ($urandom_range(0, 2) != 0);
      mispredictFlush = ($urandom_range(0, 39) == 0);
      earlyMisdirect = ($urandom_range(0, 39) == 0);
      step();
    end
    mispredictFlush = 1'b0; earlyMisdirect = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
